// File: rtl/retire_unit_pkg.sv
// -----------------------------------------------------------------------------
// retire_unit_pkg
//   Shared configuration and types for the ROB completion/retirement block.
//   ROB geometry and register widths live here so the top, the pointer
//   sub-module and the row typedef always agree.
//
//   Optional feature macro used by the top: DUAL_RETIRE_EN
// -----------------------------------------------------------------------------
package retire_unit_pkg;

  localparam int ROB_DEPTH = 16;               // power of two
  localparam int PREG_W    = 6;
  localparam int AREG_W    = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_FU    = 3;
  localparam int IDX_W     = $clog2(ROB_DEPTH);

  // Allocation is allowed while at least two entries are free, judged on the
  // registered occupancy (same-cycle retirements are not credited).
  localparam logic [IDX_W:0] ALLOC_READY_MAX = (IDX_W+1)'(ROB_DEPTH - 2);

  // RISC-V major opcodes used to tag the instruction class of a ROB row.
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;

  typedef struct packed {
    logic              v;
    logic              complete;
    logic [6:0]        instr_type;
    logic [PREG_W-1:0] phy_reg;
    logic [PREG_W-1:0] old_phy_reg;
    logic [AREG_W-1:0] arch_reg;
  } rob_row_t;

  // Dispatch only tells us store / not-store; non-stores are tagged with the
  // load opcode, which stands for "writes a register at retire".
  function automatic logic [6:0] instr_class(input logic is_store);
    return is_store ? OPC_SW : OPC_LW;
  endfunction

  function automatic logic is_store_op(input logic [6:0] op);
    return (op == OPC_SW);
  endfunction

endpackage

// File: rtl/retire_unit_rob_ptr.sv
// -----------------------------------------------------------------------------
// rob_ptr
//   ROB pointer register with an extra wrap bit above the index. Advances by
//   0, 1 or 2 per cycle; because the depth is a power of two the wrap bit
//   toggles naturally when the index rolls over, with no bubble.
//
//   Ports:
//     clk    in   core clock
//     rst_n  in   asynchronous active-low reset (pointer -> 0)
//     i_adv  in   advance amount (0..2)
//     o_ptr  out  {wrap, index}
// -----------------------------------------------------------------------------
module rob_ptr
  import retire_unit_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     i_adv,
  output logic [IDX_W:0] o_ptr
);

  logic [IDX_W:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= r_ptr + {{(IDX_W-1){1'b0}}, i_adv};
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/retire_unit.sv
// -----------------------------------------------------------------------------
// retire_unit
//   Completion and in-order retirement end of the issue/execute interface.
//   Takes up to two ROB allocations per cycle, up to three FU results per
//   cycle (registered PRF writeback / wake-up and FU release), and retires
//   the oldest completed entries in program order.
//
//   Optional feature macro: DUAL_RETIRE_EN
//     defined   : up to two retirements per cycle
//     undefined : slot-2 retire outputs tied to 0, head advances by <= 1
//
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     alloc_valid/preg/old_preg/areg/is_store_{1,2}  dispatch allocation slots
//     alloc_ready                    at least two free entries
//     alloc_idx_{1,2}                indices the next allocations receive
//     result_valid/ROB/dest/_/FU_{1..3}  FU result channels
//     wb_en/wb_preg/wb_data_{1..3}   registered PRF write + wake-up
//     fu_release                     registered one-hot FU ready (FU index 0..2)
//     retire_valid/areg/preg/free_preg/is_store_{1,2}  retiring entries
//     rob_count                      occupied entries
//     err                            sticky protocol error
// -----------------------------------------------------------------------------
module retire_unit
  import retire_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  // allocation
  input  logic              alloc_valid_1,
  input  logic              alloc_valid_2,
  input  logic [PREG_W-1:0] alloc_preg_1,
  input  logic [PREG_W-1:0] alloc_preg_2,
  input  logic [PREG_W-1:0] alloc_old_preg_1,
  input  logic [PREG_W-1:0] alloc_old_preg_2,
  input  logic [AREG_W-1:0] alloc_areg_1,
  input  logic [AREG_W-1:0] alloc_areg_2,
  input  logic              alloc_is_store_1,
  input  logic              alloc_is_store_2,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx_1,
  output logic [IDX_W-1:0]  alloc_idx_2,
  // results
  input  logic              result_valid_1,
  input  logic              result_valid_2,
  input  logic              result_valid_3,
  input  logic [IDX_W-1:0]  result_ROB_1,
  input  logic [IDX_W-1:0]  result_ROB_2,
  input  logic [IDX_W-1:0]  result_ROB_3,
  input  logic [PREG_W-1:0] result_dest_1,
  input  logic [PREG_W-1:0] result_dest_2,
  input  logic [PREG_W-1:0] result_dest_3,
  input  logic [DATA_W-1:0] result_1,
  input  logic [DATA_W-1:0] result_2,
  input  logic [DATA_W-1:0] result_3,
  input  logic [1:0]        result_FU_1,
  input  logic [1:0]        result_FU_2,
  input  logic [1:0]        result_FU_3,
  // writeback / wake-up
  output logic              wb_en_1,
  output logic              wb_en_2,
  output logic              wb_en_3,
  output logic [PREG_W-1:0] wb_preg_1,
  output logic [PREG_W-1:0] wb_preg_2,
  output logic [PREG_W-1:0] wb_preg_3,
  output logic [DATA_W-1:0] wb_data_1,
  output logic [DATA_W-1:0] wb_data_2,
  output logic [DATA_W-1:0] wb_data_3,
  output logic [2:0]        fu_release,
  // retirement
  output logic              retire_valid_1,
  output logic              retire_valid_2,
  output logic [AREG_W-1:0] retire_areg_1,
  output logic [AREG_W-1:0] retire_areg_2,
  output logic [PREG_W-1:0] retire_preg_1,
  output logic [PREG_W-1:0] retire_preg_2,
  output logic [PREG_W-1:0] retire_free_preg_1,
  output logic [PREG_W-1:0] retire_free_preg_2,
  output logic              retire_is_store_1,
  output logic              retire_is_store_2,
  // status
  output logic [IDX_W:0]    rob_count,
  output logic              err
);

  // ---------------------------------------------------------------------------
  // Pointers
  // ---------------------------------------------------------------------------
  logic [IDX_W:0]   w_head_ptr;
  logic [IDX_W:0]   w_tail_ptr;
  logic [IDX_W-1:0] w_head_idx;
  logic [IDX_W-1:0] w_tail_idx;
  logic [IDX_W-1:0] w_tail_idx_p1;
  logic [1:0]       w_head_adv;
  logic [1:0]       w_tail_adv;

  rob_ptr u_head_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_adv (w_head_adv),
    .o_ptr (w_head_ptr)
  );

  rob_ptr u_tail_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_adv (w_tail_adv),
    .o_ptr (w_tail_ptr)
  );

  assign w_head_idx    = w_head_ptr[IDX_W-1:0];
  assign w_tail_idx    = w_tail_ptr[IDX_W-1:0];
  assign w_tail_idx_p1 = w_tail_idx + IDX_W'(1);

  // With a wrap bit on each pointer the modular difference is the occupancy:
  // 0 when empty (all bits equal), ROB_DEPTH when full (index equal, wrap
  // bits differ).
  assign rob_count   = w_tail_ptr - w_head_ptr;
  assign alloc_ready = (rob_count <= ALLOC_READY_MAX);
  assign alloc_idx_1 = w_tail_idx;
  assign alloc_idx_2 = w_tail_idx_p1;

  // ---------------------------------------------------------------------------
  // Allocation
  // ---------------------------------------------------------------------------
  rob_row_t r_rob [ROB_DEPTH];
  rob_row_t w_row1;
  rob_row_t w_row2;
  logic     w_acc1;
  logic     w_acc2;
  logic     w_alloc_err;

  assign w_acc1      = alloc_valid_1 & alloc_ready;
  assign w_acc2      = w_acc1 & alloc_valid_2;
  assign w_alloc_err = ((alloc_valid_1 | alloc_valid_2) & ~alloc_ready) |
                       (alloc_valid_2 & ~alloc_valid_1);
  assign w_tail_adv  = {w_acc2, w_acc1 & ~w_acc2};

  always_comb begin
    w_row1             = '0;
    w_row1.v           = 1'b1;
    w_row1.instr_type  = instr_class(alloc_is_store_1);
    w_row1.phy_reg     = alloc_preg_1;
    w_row1.old_phy_reg = alloc_old_preg_1;
    w_row1.arch_reg    = alloc_areg_1;
    w_row2             = '0;
    w_row2.v           = 1'b1;
    w_row2.instr_type  = instr_class(alloc_is_store_2);
    w_row2.phy_reg     = alloc_preg_2;
    w_row2.old_phy_reg = alloc_old_preg_2;
    w_row2.arch_reg    = alloc_areg_2;
  end

  // ---------------------------------------------------------------------------
  // Result channels
  // ---------------------------------------------------------------------------
  logic [NUM_FU-1:0] w_res_valid;
  logic [IDX_W-1:0]  w_res_rob  [NUM_FU];
  logic [PREG_W-1:0] w_res_dest [NUM_FU];
  logic [DATA_W-1:0] w_res_data [NUM_FU];
  logic [1:0]        w_res_fu   [NUM_FU];
  logic [NUM_FU-1:0] w_res_hit;
  logic [NUM_FU-1:0] w_res_err;
  logic [NUM_FU-1:0] w_rel_next;

  assign w_res_valid   = {result_valid_3, result_valid_2, result_valid_1};
  assign w_res_rob[0]  = result_ROB_1;
  assign w_res_rob[1]  = result_ROB_2;
  assign w_res_rob[2]  = result_ROB_3;
  assign w_res_dest[0] = result_dest_1;
  assign w_res_dest[1] = result_dest_2;
  assign w_res_dest[2] = result_dest_3;
  assign w_res_data[0] = result_1;
  assign w_res_data[1] = result_2;
  assign w_res_data[2] = result_3;
  assign w_res_fu[0]   = result_FU_1;
  assign w_res_fu[1]   = result_FU_2;
  assign w_res_fu[2]   = result_FU_3;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_res
      logic w_dup;

      // A channel is a duplicate if any lower-numbered channel names the same
      // entry this cycle; the lower one already sets complete.
      always_comb begin
        w_dup = 1'b0;
        for (int j = 0; j < gi; j++) begin
          if (w_res_valid[j] && (w_res_rob[j] == w_res_rob[gi])) begin
            w_dup = 1'b1;
          end
        end
      end

      assign w_res_hit[gi] = w_res_valid[gi] & r_rob[w_res_rob[gi]].v;
      assign w_res_err[gi] = w_res_valid[gi] & (~r_rob[w_res_rob[gi]].v | w_dup);
    end
  endgenerate

  // FU index 3 does not exist and releases nothing.
  always_comb begin
    w_rel_next = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (w_res_valid[k] && (w_res_fu[k] < 2'(NUM_FU))) begin
        w_rel_next[w_res_fu[k]] = 1'b1;
      end
    end
  end

  // Writeback passes through regardless of ROB state, including duplicates
  // and results naming a free entry.
  logic [NUM_FU-1:0] r_wb_en;
  logic [PREG_W-1:0] r_wb_preg [NUM_FU];
  logic [DATA_W-1:0] r_wb_data [NUM_FU];
  logic [2:0]        r_fu_release;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en      <= '0;
      r_fu_release <= '0;
      for (int k = 0; k < NUM_FU; k++) begin
        r_wb_preg[k] <= '0;
        r_wb_data[k] <= '0;
      end
    end else begin
      r_wb_en      <= w_res_valid;
      r_fu_release <= w_rel_next;
      for (int k = 0; k < NUM_FU; k++) begin
        r_wb_preg[k] <= w_res_dest[k];
        r_wb_data[k] <= w_res_data[k];
      end
    end
  end

  assign wb_en_1    = r_wb_en[0];
  assign wb_en_2    = r_wb_en[1];
  assign wb_en_3    = r_wb_en[2];
  assign wb_preg_1  = r_wb_preg[0];
  assign wb_preg_2  = r_wb_preg[1];
  assign wb_preg_3  = r_wb_preg[2];
  assign wb_data_1  = r_wb_data[0];
  assign wb_data_2  = r_wb_data[1];
  assign wb_data_3  = r_wb_data[2];
  assign fu_release = r_fu_release;

  // ---------------------------------------------------------------------------
  // Retirement (combinational from registered state)
  // ---------------------------------------------------------------------------
  rob_row_t w_head_row;
  logic     w_ret1;
  logic     w_ret2;

  assign w_head_row = r_rob[w_head_idx];
  assign w_ret1     = w_head_row.v & w_head_row.complete;

  assign retire_valid_1     = w_ret1;
  assign retire_areg_1      = w_ret1 ? w_head_row.arch_reg    : '0;
  assign retire_preg_1      = w_ret1 ? w_head_row.phy_reg     : '0;
  assign retire_free_preg_1 = w_ret1 ? w_head_row.old_phy_reg : '0;
  assign retire_is_store_1  = w_ret1 & is_store_op(w_head_row.instr_type);

`ifdef DUAL_RETIRE_EN
  logic [IDX_W-1:0] w_head_idx_p1;
  rob_row_t         w_head_row2;

  assign w_head_idx_p1 = w_head_idx + IDX_W'(1);
  assign w_head_row2   = r_rob[w_head_idx_p1];
  assign w_ret2        = w_ret1 & w_head_row2.v & w_head_row2.complete;

  assign retire_areg_2      = w_ret2 ? w_head_row2.arch_reg    : '0;
  assign retire_preg_2      = w_ret2 ? w_head_row2.phy_reg     : '0;
  assign retire_free_preg_2 = w_ret2 ? w_head_row2.old_phy_reg : '0;
  assign retire_is_store_2  = w_ret2 & is_store_op(w_head_row2.instr_type);
`else
  assign w_ret2             = 1'b0;
  assign retire_areg_2      = '0;
  assign retire_preg_2      = '0;
  assign retire_free_preg_2 = '0;
  assign retire_is_store_2  = 1'b0;
`endif

  assign retire_valid_2 = w_ret2;
  // w_ret2 implies w_ret1, so this encodes 0/1/2.
  assign w_head_adv     = {w_ret2, w_ret1 & ~w_ret2};

  // ---------------------------------------------------------------------------
  // ROB storage. Completion, retire-clear and allocation never target the
  // same live entry: allocation only writes free slots (occupancy <= depth-2),
  // and retirement clears the oldest occupied ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        if (w_res_hit[k]) begin
          r_rob[w_res_rob[k]].complete <= 1'b1;
        end
      end
      if (w_ret1) begin
        r_rob[w_head_idx] <= '0;
      end
`ifdef DUAL_RETIRE_EN
      if (w_ret2) begin
        r_rob[w_head_idx_p1] <= '0;
      end
`endif
      if (w_acc1) begin
        r_rob[w_tail_idx] <= w_row1;
      end
      if (w_acc2) begin
        r_rob[w_tail_idx_p1] <= w_row2;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky protocol error
  // ---------------------------------------------------------------------------
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_alloc_err | (|w_res_err);
    end
  end

  assign err = r_err;

endmodule

// File: tb/tb_retire_unit.sv
// -----------------------------------------------------------------------------
// tb_retire_unit
//   Table-driven directed vectors plus hand-written sequences; a retirement
//   scoreboard queue is filled at accepted allocation and drained as the DUT
//   retires. A small ROB model predicts when retirement happens.
// -----------------------------------------------------------------------------
module tb_retire_unit;

`ifdef DUAL_RETIRE_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        av1, av2, as1, as2;
  logic [5:0]  ap1, ap2, ao1, ao2;
  logic [4:0]  aa1, aa2;
  logic        rv   [3];
  logic [3:0]  rrob [3];
  logic [5:0]  rdst [3];
  logic [31:0] rdat [3];
  logic [1:0]  rfu  [3];

  logic        alloc_ready;
  logic [3:0]  aidx1, aidx2;
  logic        wen   [3];
  logic [5:0]  wpreg [3];
  logic [31:0] wdata [3];
  logic [2:0]  fu_release;
  logic        rtv1, rtv2, rst1, rst2;
  logic [4:0]  rar1, rar2;
  logic [5:0]  rpr1, rpr2, rfr1, rfr2;
  logic [4:0]  rob_count;
  logic        err;

  retire_unit dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_1(av1), .alloc_valid_2(av2),
    .alloc_preg_1(ap1), .alloc_preg_2(ap2),
    .alloc_old_preg_1(ao1), .alloc_old_preg_2(ao2),
    .alloc_areg_1(aa1), .alloc_areg_2(aa2),
    .alloc_is_store_1(as1), .alloc_is_store_2(as2),
    .alloc_ready(alloc_ready), .alloc_idx_1(aidx1), .alloc_idx_2(aidx2),
    .result_valid_1(rv[0]), .result_valid_2(rv[1]), .result_valid_3(rv[2]),
    .result_ROB_1(rrob[0]), .result_ROB_2(rrob[1]), .result_ROB_3(rrob[2]),
    .result_dest_1(rdst[0]), .result_dest_2(rdst[1]), .result_dest_3(rdst[2]),
    .result_1(rdat[0]), .result_2(rdat[1]), .result_3(rdat[2]),
    .result_FU_1(rfu[0]), .result_FU_2(rfu[1]), .result_FU_3(rfu[2]),
    .wb_en_1(wen[0]), .wb_en_2(wen[1]), .wb_en_3(wen[2]),
    .wb_preg_1(wpreg[0]), .wb_preg_2(wpreg[1]), .wb_preg_3(wpreg[2]),
    .wb_data_1(wdata[0]), .wb_data_2(wdata[1]), .wb_data_3(wdata[2]),
    .fu_release(fu_release),
    .retire_valid_1(rtv1), .retire_valid_2(rtv2),
    .retire_areg_1(rar1), .retire_areg_2(rar2),
    .retire_preg_1(rpr1), .retire_preg_2(rpr2),
    .retire_free_preg_1(rfr1), .retire_free_preg_2(rfr2),
    .retire_is_store_1(rst1), .retire_is_store_2(rst2),
    .rob_count(rob_count), .err(err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  typedef struct {
    logic [4:0] areg;
    logic [5:0] preg;
    logic [5:0] old;
    logic       st;
  } rec_t;

  rec_t       sbq [$];
  bit         mv [16];
  bit         mc [16];
  logic [5:0] mpreg [16];
  logic [4:0] mh, mt;
  bit         merr;
  bit         pw_en   [3];
  logic [5:0] pw_preg [3];
  logic [31:0] pw_data [3];
  logic [2:0] p_rel;
  int         nseq;

  task automatic idle();
    av1 = 0; av2 = 0; as1 = 0; as2 = 0;
    ap1 = '0; ap2 = '0; ao1 = '0; ao2 = '0; aa1 = '0; aa2 = '0;
    for (int k = 0; k < 3; k++) begin
      rv[k] = 0; rrob[k] = '0; rdst[k] = '0; rdat[k] = '0; rfu[k] = '0;
    end
  endtask

  // Allocation payload derived from the sequence number of accepted entries.
  task automatic set_alloc(input bit v1, input bit v2);
    av1 = v1; av2 = v2;
    ap1 = 6'(33 + nseq); ao1 = 6'(3 + nseq); aa1 = 5'(1 + nseq); as1 = (nseq % 5 == 3);
    ap2 = 6'(34 + nseq); ao2 = 6'(4 + nseq); aa2 = 5'(2 + nseq); as2 = ((nseq + 1) % 5 == 3);
  endtask

  task automatic set_res(input int k, input logic [3:0] rob, input logic [31:0] d);
    rv[k] = 1; rrob[k] = rob; rdst[k] = mpreg[rob]; rdat[k] = d; rfu[k] = 2'(k);
  endtask

  task automatic chk_ret(input string slot, input logic [4:0] ar, input logic [5:0] pr,
                         input logic [5:0] fr, input logic st);
    rec_t r;
    if (sbq.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s_unexpected: retire with empty scoreboard", slot);
    end else begin
      r = sbq.pop_front();
      $display("[TB] retire %s areg=%0d preg=%0d free=%0d st=%0d", slot, ar, pr, fr, st);
      chk({slot, "_areg"}, ar, r.areg);
      chk({slot, "_preg"}, pr, r.preg);
      chk({slot, "_free_preg"}, fr, r.old);
      chk({slot, "_is_store"}, st, r.st);
    end
  endtask

  // Called at the negedge right after inputs are driven: checks outputs of
  // the current registered state, advances the model, then crosses one edge.
  task automatic step();
    bit e1, e2, a1, a2, rdy;
    logic [3:0] hi, hi1, ti;
    #1;
    hi  = mh[3:0];
    hi1 = hi + 4'd1;
    e1  = mv[hi] && mc[hi];
    e2  = DUAL && e1 && mv[hi1] && mc[hi1];
    chk("retire_valid_1", rtv1, e1);
    chk("retire_valid_2", rtv2, e2);
    if (rtv1) chk_ret("r1", rar1, rpr1, rfr1, rst1);
    if (rtv2) chk_ret("r2", rar2, rpr2, rfr2, rst2);
    rdy = (5'(mt - mh) <= 5'd14);
    chk("rob_count", rob_count, 5'(mt - mh));
    chk("alloc_ready", alloc_ready, rdy);
    chk("alloc_idx_1", aidx1, mt[3:0]);
    chk("alloc_idx_2", aidx2, 4'(mt[3:0] + 4'd1));
    chk("err", err, merr);
    for (int k = 0; k < 3; k++) begin
      chk("wb_en", wen[k], pw_en[k]);
      if (pw_en[k]) begin
        chk("wb_preg", wpreg[k], pw_preg[k]);
        chk("wb_data", wdata[k], pw_data[k]);
      end
    end
    chk("fu_release", fu_release, p_rel);

    // model update for the coming edge
    if ((av1 || av2) && !rdy) merr = 1;
    if (av2 && !av1) merr = 1;
    a1 = av1 && rdy;
    a2 = a1 && av2;
    p_rel = '0;
    for (int k = 0; k < 3; k++) begin
      pw_en[k] = rv[k]; pw_preg[k] = rdst[k]; pw_data[k] = rdat[k];
      if (rv[k]) begin
        p_rel[rfu[k]] = 1'b1;
        if (!mv[rrob[k]]) merr = 1;
        else mc[rrob[k]] = 1;
        for (int j = 0; j < k; j++)
          if (rv[j] && rrob[j] == rrob[k]) merr = 1;
      end
    end
    if (e1) begin mv[hi] = 0; mc[hi] = 0; end
    if (e2) begin mv[hi1] = 0; mc[hi1] = 0; end
    mh = mh + 5'(e1) + 5'(e2);
    ti = mt[3:0];
    if (a1) begin
      mv[ti] = 1; mc[ti] = 0; mpreg[ti] = ap1;
      sbq.push_back('{areg: aa1, preg: ap1, old: ao1, st: as1});
    end
    if (a2) begin
      mv[4'(ti + 4'd1)] = 1; mc[4'(ti + 4'd1)] = 0; mpreg[4'(ti + 4'd1)] = ap2;
      sbq.push_back('{areg: aa2, preg: ap2, old: ao2, st: as2});
    end
    mt = mt + 5'(a1) + 5'(a2);
    nseq = nseq + int'(a1) + int'(a2);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Async reset asserted mid-cycle; entries must vanish immediately.
  task automatic do_reset();
    idle();
    #2;
    rst_n = 0;
    #1;
    chk("async_reset_count", rob_count, 5'd0);
    chk("async_reset_retire", rtv1, 1'b0);
    chk("async_reset_ready", alloc_ready, 1'b1);
    for (int i = 0; i < 16; i++) begin mv[i] = 0; mc[i] = 0; mpreg[i] = '0; end
    mh = '0; mt = '0; merr = 0; nseq = 0; p_rel = '0;
    for (int k = 0; k < 3; k++) pw_en[k] = 0;
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit [1:0]    av;
    bit [1:0]    rv;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] da;
    logic [31:0] db;
    int          cnt_d;
    int          cnt_s;
    int          ret_d;
    int          ret_s;
  } vec_t;

  vec_t vt [11];

  initial begin
    int guard;
    // av, rv, rob_a, rob_b, data_a, data_b, count(dual,single), retires(dual,single)
    vt[0]  = '{2'b11, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0, 0, 0, 0, 0};
    vt[1]  = '{2'b00, 2'b11, 4'd0, 4'd1, 32'h5,  32'hA, 2, 2, 0, 0};
    vt[2]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0, 2, 2, 2, 1};
    vt[3]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0, 0, 1, 0, 1};
    vt[4]  = '{2'b11, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0, 0, 0, 0, 0};
    vt[5]  = '{2'b00, 2'b01, 4'd3, 4'd0, 32'h33, 32'h0, 2, 2, 0, 0};
    vt[6]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0, 2, 2, 0, 0};
    vt[7]  = '{2'b00, 2'b10, 4'd0, 4'd2, 32'h0, 32'h22, 2, 2, 0, 0};
    vt[8]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0, 2, 2, 2, 1};
    vt[9]  = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0, 0, 1, 0, 1};
    vt[10] = '{2'b00, 2'b00, 4'd0, 4'd0, 32'h0,  32'h0, 0, 0, 0, 0};

    idle();
    @(negedge clk);
    do_reset();
    chk("reset_idx2", aidx2, 4'd1);
    chk("reset_err", err, 1'b0);

    for (int i = 0; i < 11; i++) begin
      idle();
      set_alloc(vt[i].av[0], vt[i].av[1]);
      if (vt[i].rv[0]) set_res(0, vt[i].ra, vt[i].da);
      if (vt[i].rv[1]) set_res(1, vt[i].rb, vt[i].db);
      chk($sformatf("tbl%0d_count", i), rob_count, 5'(DUAL ? vt[i].cnt_d : vt[i].cnt_s));
      chk($sformatf("tbl%0d_retires", i), 2'(rtv1) + 2'(rtv2), 2'(DUAL ? vt[i].ret_d : vt[i].ret_s));
      step();
    end
    chk("tbl_err_clean", err, 1'b0);

    // result to a free entry
    do_reset();
    idle(); set_alloc(1, 1); step();
    idle(); set_res(0, 4'd7, 32'h77); step();
    chk("err_invalid_rob", err, 1'b1);
    idle(); step(); step();

    // duplicate index across FU1/FU3
    do_reset();
    idle(); set_alloc(1, 1); step();
    idle(); set_res(0, 4'd0, 32'h11); set_res(2, 4'd0, 32'h33); step();
    chk("err_duplicate", err, 1'b1);
    chk("dup_release", fu_release, 3'b101);
    idle(); step();
    idle(); set_res(1, 4'd1, 32'h44); step();
    idle(); step(); step();

    // fill until alloc_ready drops, then overflow attempt
    do_reset();
    for (int i = 0; i < 8; i++) begin idle(); set_alloc(1, 1); step(); end
    chk("full_ready", alloc_ready, 1'b0);
    chk("full_count", rob_count, 5'd16);
    idle(); set_alloc(1, 1); step();
    chk("overflow_err", err, 1'b1);
    chk("overflow_count_hold", rob_count, 5'd16);
    for (int i = 0; i < 16; i++) begin idle(); set_res(i % 3, 4'(i), 32'(i)); step(); end
    guard = 0;
    idle();
    while (mt != mh && guard < 40) begin step(); guard++; end
    chk("fill_drain_timeout", guard < 40, 1'b1);

    // 20 alloc/retire pairs with pointer wrap
    do_reset();
    for (int i = 0; i < 22; i++) begin
      idle();
      if (i < 20) set_alloc(1, 0);
      if (i > 0 && i <= 20) set_res(1, 4'(i - 1), 32'(100 + i));
      step();
    end
    idle(); step(); step();
    chk("wrap_empty", rob_count, 5'd0);
    chk("wrap_tail_idx", aidx1, 4'd4);
    chk("wrap_scoreboard_empty", sbq.size(), 0);

    // reset in the middle of operation
    idle(); set_alloc(1, 1); step();
    idle(); set_res(0, 4'(mt[3:0] - 4'd2), 32'h9); step();
    do_reset();
    idle(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
